// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN classifier datapath.
//   argmax_sched_state_t : sequencer FSM states for argmax_sched
//   idx_width()          : index width needed to address a vector of a given length
package cnn_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StHold
    } argmax_sched_state_t;

    // A single-element vector still gets a 1-bit index port.
    function automatic int unsigned idx_width(input int unsigned dim);
        return (dim <= 1) ? 1 : $clog2(dim);
    endfunction

endpackage

// File: rtl/argmax.sv
// Sequential argmax engine: scans one logit per cycle and reports the index of
// the largest signed value; ties keep the lowest index.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : one-cycle pulse, begins a scan of vec
//   vec         : logit vector, must stay stable until done
//   done        : one-cycle pulse, DIM+1 cycles after start
//   idx         : winning index, valid while done is high
module argmax
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DIM        = 10,
    parameter int unsigned IDXW       = idx_width(DIM)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] vec [0:DIM-1],
    output logic                         done,
    output logic        [IDXW-1:0]       idx
);

    localparam logic [IDXW-1:0] LastIdx = IDXW'(DIM - 1);

    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic        [IDXW-1:0]       cnt_q, cnt_d;
    logic        [IDXW-1:0]       best_idx_q, best_idx_d;
    logic signed [DATA_WIDTH-1:0] best_q, best_d;

    always_comb begin
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        best_idx_d = best_idx_q;
        done_d     = 1'b0;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
        end else if (busy_q) begin
            // Element 0 seeds the running maximum; strict '>' keeps first occurrence.
            if ((cnt_q == '0) || (vec[cnt_q] > best_q)) begin
                best_d     = vec[cnt_q];
                best_idx_d = cnt_q;
            end
            if (cnt_q == LastIdx) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
        end else begin
            busy_q     <= busy_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            best_idx_q <= best_idx_d;
            best_q     <= best_d;
        end
    end

    assign done = done_q;
    assign idx  = best_idx_q;

endmodule

// File: rtl/argmax_sched.sv
// Sequencer and double buffer in front of the argmax engine. Snapshots incoming
// logit vectors, launches the engine, parks a finished index when the output is
// stalled and presents results with a wrapping sequence tag.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   flush                : synchronous abort of all buffered/in-flight frames
//   in_valid/in_ready    : input handshake, in_vec carries DIM signed logits
//   out_valid/out_ready  : output handshake for out_idx/out_seq
//   busy                 : a frame is buffered, being scanned or held
module argmax_sched
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DIM        = 10,
    parameter int unsigned IDXW       = idx_width(DIM),
    parameter int unsigned SEQW       = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_vec [0:DIM-1],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [IDXW-1:0]       out_idx,
    output logic        [SEQW-1:0]       out_seq,
    output logic                         busy
);

    typedef logic signed [DATA_WIDTH-1:0] vec_t [0:DIM-1];

    argmax_sched_state_t state_q, state_d;

    vec_t            snap_q, snap_d;
    vec_t            pend_q, pend_d;
    logic            snap_full_q, snap_full_d;
    logic            pend_full_q, pend_full_d;
    logic [IDXW-1:0] hold_idx_q, hold_idx_d;
    logic [IDXW-1:0] out_idx_q, out_idx_d;
    logic [SEQW-1:0] out_seq_q, out_seq_d;
    logic            out_valid_q, out_valid_d;
    logic [SEQW-1:0] seq_cnt_q, seq_cnt_d;

    logic            accept;
    logic            slot_free;
    logic            retire;
    logic [IDXW-1:0] retire_idx;
    logic            eng_start;
    logic            eng_done;
    logic [IDXW-1:0] eng_idx;
    logic            eng_reset;

    assign eng_reset = reset | flush;

    argmax #(
        .DATA_WIDTH(DATA_WIDTH),
        .DIM       (DIM),
        .IDXW      (IDXW)
    ) u_argmax (
        .clk  (clk),
        .reset(eng_reset),
        .start(eng_start),
        .vec  (snap_q),
        .done (eng_done),
        .idx  (eng_idx)
    );

    // State and buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            snap_full_q <= 1'b0;
            pend_full_q <= 1'b0;
            hold_idx_q  <= '0;
            out_idx_q   <= '0;
            out_seq_q   <= '0;
            out_valid_q <= 1'b0;
            seq_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            snap_full_q <= snap_full_d;
            pend_full_q <= pend_full_d;
            hold_idx_q  <= hold_idx_d;
            out_idx_q   <= out_idx_d;
            out_seq_q   <= out_seq_d;
            out_valid_q <= out_valid_d;
            seq_cnt_q   <= seq_cnt_d;
        end
    end

    // Vector payloads are qualified by the *_full flags and need no reset.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
        pend_q <= pend_d;
    end

    // Next-state and buffer steering.
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        pend_d      = pend_q;
        snap_full_d = snap_full_q;
        pend_full_d = pend_full_q;
        hold_idx_d  = hold_idx_q;
        out_idx_d   = out_idx_q;
        out_seq_d   = out_seq_q;
        out_valid_d = out_valid_q;
        seq_cnt_d   = seq_cnt_q;
        retire      = 1'b0;
        retire_idx  = eng_idx;

        accept    = in_valid && in_ready;
        slot_free = !out_valid_q || out_ready;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    snap_d      = in_vec;
                    snap_full_d = 1'b1;
                    state_d     = StLaunch;
                end
            end
            StLaunch: begin
                state_d = StWait;
            end
            StWait: begin
                if (eng_done) begin
                    if (slot_free) begin
                        retire = 1'b1;
                    end else begin
                        hold_idx_d = eng_idx;
                        state_d    = StHold;
                    end
                end
            end
            StHold: begin
                if (slot_free) begin
                    retire     = 1'b1;
                    retire_idx = hold_idx_q;
                end
            end
            default: state_d = StIdle;
        endcase

        // Outside IDLE an accepted vector queues in pend, unless a retire this
        // cycle frees snap; pend is necessarily empty whenever accept is high.
        if (accept && (state_q != StIdle) && !retire) begin
            pend_d      = in_vec;
            pend_full_d = 1'b1;
        end

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (retire && !flush) begin
            out_idx_d   = retire_idx;
            out_valid_d = 1'b1;
            out_seq_d   = seq_cnt_q;
            seq_cnt_d   = seq_cnt_q + 1'b1;
            if (pend_full_q) begin
                snap_d      = pend_q;
                pend_full_d = 1'b0;
                state_d     = StLaunch;
            end else if (accept) begin
                snap_d  = in_vec;
                state_d = StLaunch;
            end else begin
                snap_full_d = 1'b0;
                state_d     = StIdle;
            end
        end

        // Sequence counter deliberately survives a flush.
        if (flush) begin
            state_d     = StIdle;
            snap_full_d = 1'b0;
            pend_full_d = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    // Outputs.
    always_comb begin
        eng_start = (state_q == StLaunch);
        in_ready  = !reset && !pend_full_q && !flush;
        busy      = snap_full_q || pend_full_q || (state_q != StIdle);
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_seq   = out_seq_q;

endmodule

// File: doc/argmax_sched.md
# argmax_sched

Sequencer and buffer in front of the shared `argmax` classification engine. It accepts logit vectors from the dense layer over a valid/ready handshake and snapshots them so the engine sees a stable vector for its whole scan. It launches the engine, collects each index, and presents results with a sequence tag to the downstream consumer (UART TX / result logger). One pending slot lets a second frame queue while the engine is busy, so back-to-back frames run at the engine's native rate.

## Interface
- `DATA_WIDTH`, default 16: signed logit width.
- `DIM`, default 10: logits per frame (≥1).
- `IDXW`, default `(DIM<=1)?1:$clog2(DIM)`: index width.
- `SEQW`, default 8: result sequence-tag width.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  synchronous abort: drops all buffered frames and any in-flight scan.
- `in_valid`  in  1  logit vector valid.
- `in_ready`  out  1  block can accept a vector.
- `in_vec`  in  DIM×DATA_WIDTH signed  logit vector `[0:DIM-1]`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_idx`  out  IDXW  argmax index.
- `out_seq`  out  SEQW  per-result tag; increments on each result produced, wraps.
- `busy`  out  1  any frame buffered, in flight, or held.

## Operation
- Storage:
  - `snap` plus `snap_full`: the vector being scanned.
  - `pend` plus `pend_full`: the queued vector.
  - `hold_idx`: the result waiting for the output slot.
  - Output register: `out_idx`, `out_seq`, `out_valid`.
- `in_ready = !pend_full && !flush`. Accepted data goes to `snap` when the state is IDLE. Otherwise it goes to `pend`.
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
  - IDLE: on accept, load `snap` and go to LAUNCH.
  - LAUNCH: drive `eng_start=1` for exactly one cycle. The engine's `vec` is wired to `snap`. Go to WAIT.
  - WAIT: on `eng_done`, retire if the output slot is free (`!out_valid || out_ready`). Otherwise latch the engine index into `hold_idx` and go to HOLD.
  - HOLD: retire as soon as the slot is free.
- Retire means, all in the same cycle:
  - Write `out_idx`, set `out_valid=1`, and set `out_seq` to the internal counter value, then increment the counter.
  - Refill `snap` from `pend` if `pend_full` (clear `pend_full`). Otherwise refill from a vector accepted this cycle. Otherwise clear `snap_full`.
  - Next state is LAUNCH if `snap` was refilled, otherwise IDLE.
- `out_valid` clears on `out_ready` when no retire happens in the same cycle. Retire and consume in the same cycle leaves `out_valid=1` with the new data.
- `snap` must never change while the state is LAUNCH or WAIT.
- `flush`:
  - Next state IDLE; clear `snap_full`, `pend_full`, and `out_valid`.
  - Engine reset is driven by `reset | flush`.
  - `out_seq` is not reset by flush.
  - Input presented during flush is not accepted.
- `reset`: all outputs 0 (`in_ready` 0 during reset and 1 the cycle after), counter 0, state IDLE.
- DIM=1: index is always 0; latency formula below still holds.

## Timing
- Accept in cycle N with the block idle:
  - LAUNCH (`eng_start`) in cycle N+1.
  - Engine done in cycle N+DIM+2.
  - `out_valid` high in cycle N+DIM+3. For DIM=10 that is cycle N+13.
- Sustained throughput with `out_ready` held high is one result every DIM+2 cycles. The retire cycle is followed directly by LAUNCH.
- At most 2 frames are buffered (`snap` + `pend`) plus 1 held result. `in_ready` deasserts only while `pend_full`.

## Structure
- Shared package `cnn_pkg` gets the `argmax_sched_state_t` enum (IDLE, LAUNCH, WAIT, HOLD) and the index-width helper function.
- One sub-module: an instance of the existing `argmax` engine (`u_argmax`). Its `idx` feeds retire/`hold_idx`; its `done` is the `eng_done` used by the FSM.
- All remaining logic is a single always_ff FSM with buffer registers and the counter.

## Test plan
- Single frame, DIM=10, vec={3,-1,7,7,0,…,0}, out_ready=1: `out_valid` rises exactly 13 cycles after accept with `out_idx=2`, `out_seq=0`. The tie at 3 keeps the first occurrence.
- Three frames offered back-to-back, out_ready=1:
  - `in_ready` drops after the second accept.
  - Results come out 12 cycles apart with `out_seq` 0,1,2.
  - Expected indices match a scoreboard.
- out_ready=0 for 40 cycles with three frames offered:
  - The first result holds stable on `out_valid`, the second waits in HOLD, and the third waits in `pend` with `in_ready=0`.
  - After release, all three drain in order with no loss or duplication.
- All values -32768 except vec[9]=-32767: `out_idx=9`. All equal: `out_idx=0`.
- Assert `flush` mid-WAIT with `pend_full`:
  - The next cycle shows `out_valid=0`, `busy=0`, `in_ready=1`.
  - A new frame then completes with the correct index, and `out_seq` continues from its pre-flush value.
- Assert `reset` mid-HOLD: all outputs 0 next cycle and `out_seq` restarts at 0.
